// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a PC-indexed BHT of 2-bit saturating counters.
// Compares full-width operands for the six B-type conditions, registers the
// outcome one cycle after the request, and keeps saturating statistics.
module branch_resolve_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int PC_LSB      = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [2:0]       res_funct3,
  input  logic [XLEN-1:0]  res_rs1,
  input  logic [XLEN-1:0]  res_rs2,
  input  logic             res_pred_taken,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [BHT_ENTRIES-1:0][1:0] bht_q;
  logic [IDX_W-1:0] pred_idx, res_idx;
  logic             eq, lts, ltu;
  logic             legal, taken, upd, mis;
  logic             out_valid_q, out_taken_q, out_mis_q, out_ill_q;
  logic             out_valid_d, out_taken_d, out_mis_d, out_ill_d;
  logic [CNT_W-1:0] bcnt_q, mcnt_q;

  // PC bits outside the index window never affect anything
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, res_pc};

  assign pred_idx = pred_pc[PC_LSB +: IDX_W];
  assign res_idx  = res_pc[PC_LSB +: IDX_W];

  // No bypass: prediction reads the pre-update counter on a collision
  assign pred_taken = bht_q[pred_idx][1];

  assign eq  = (res_rs1 == res_rs2);
  assign lts = ($signed(res_rs1) < $signed(res_rs2));
  assign ltu = (res_rs1 < res_rs2);

  // Decode funct3 into the actual outcome; 010/011 are illegal and not taken
  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (res_funct3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lts;
      3'b101:  taken = ~lts;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: legal = 1'b0;
    endcase
  end

  // BHT and statistics ignore flush: the branch did execute
  assign upd = res_valid & legal;
  assign mis = legal & (taken != res_pred_taken);

  assign out_valid_d = res_valid & ~flush;
  assign out_taken_d = out_valid_d & taken;
  assign out_mis_d   = out_valid_d & mis;
  assign out_ill_d   = out_valid_d & ~legal;

  // BHT counters: saturating increment on taken, decrement on not-taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (upd) begin
      if (taken && bht_q[res_idx] != 2'b11)
        bht_q[res_idx] <= bht_q[res_idx] + 2'b01;
      else if (!taken && bht_q[res_idx] != 2'b00)
        bht_q[res_idx] <= bht_q[res_idx] - 2'b01;
    end
  end

  // Registered resolution result, one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
      out_mis_q   <= 1'b0;
      out_ill_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_taken_q <= out_taken_d;
      out_mis_q   <= out_mis_d;
      out_ill_q   <= out_ill_d;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (upd) begin
      if (bcnt_q != CNT_MAX) bcnt_q <= bcnt_q + 1'b1;
      if (mis && mcnt_q != CNT_MAX) mcnt_q <= mcnt_q + 1'b1;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_mispredict   = out_mis_q;
  assign out_illegal      = out_ill_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: vector table plus multi-cycle sequences.
module tb_branch_resolve_bht;
  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [31:0] pred_pc, res_pc, res_rs1, res_rs2;
  logic        pred_taken, res_valid, res_pred_taken;
  logic [2:0]  res_funct3;
  logic        out_valid, out_taken, out_mispredict, out_illegal;
  logic [3:0]  branch_count, mispredict_count;

  int total = 0;
  int bad   = 0;
  int bexp  = 0;
  int mexp  = 0;

  branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(256), .PC_LSB(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
    .res_rs1(res_rs1), .res_rs2(res_rs2), .res_pred_taken(res_pred_taken),
    .out_valid(out_valid), .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        pt;
    logic        e_taken, e_mis, e_ill;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected statistics with CNT_W=4 saturation
  task automatic model(input logic legal, input logic m);
    if (legal) begin
      if (bexp != 15) bexp++;
      if (m && mexp != 15) mexp++;
    end
  endtask

  task automatic chk_cnt(input string name);
    chk({name, ".bcnt"}, {28'd0, branch_count}, bexp);
    chk({name, ".mcnt"}, {28'd0, mispredict_count}, mexp);
  endtask

  task automatic req(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic pt, input logic fl);
    res_valid = 1'b1; res_pc = pc; res_funct3 = f3;
    res_rs1 = a; res_rs2 = b; res_pred_taken = pt; flush = fl;
    @(posedge clk); #1;
    res_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic v, input logic t,
                         input logic m, input logic il);
    chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({name, ".taken"}, {31'd0, out_taken}, {31'd0, t});
    chk({name, ".mis"},   {31'd0, out_mispredict}, {31'd0, m});
    chk({name, ".ill"},   {31'd0, out_illegal}, {31'd0, il});
  endtask

  task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
    pred_pc = pc; #1;
    chk(name, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  initial begin
    vt[0]  = '{3'b100, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0}; // blt
    vt[1]  = '{3'b110, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0}; // bltu
    vt[2]  = '{3'b101, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0}; // bge
    vt[3]  = '{3'b111, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0}; // bgeu
    vt[4]  = '{3'b000, 32'h3,        32'h4, 1'b0, 1'b0, 1'b0, 1'b0}; // beq ne
    vt[5]  = '{3'b001, 32'h3,        32'h4, 1'b0, 1'b1, 1'b1, 1'b0}; // bne
    vt[6]  = '{3'b100, 32'h1,        32'h1, 1'b0, 1'b0, 1'b0, 1'b0}; // blt eq
    vt[7]  = '{3'b101, 32'h1,        32'h1, 1'b1, 1'b1, 1'b0, 1'b0}; // bge eq
    vt[8]  = '{3'b110, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0}; // bltu
    vt[9]  = '{3'b111, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}; // bgeu
    vt[10] = '{3'b011, 32'h5,        32'h5, 1'b1, 1'b0, 1'b0, 1'b1}; // illegal
    vt[11] = '{3'b010, 32'h5,        32'h5, 1'b1, 1'b0, 1'b0, 1'b1}; // illegal

    rst_n = 1'b0; flush = 1'b0; res_valid = 1'b0; res_pc = '0; res_funct3 = '0;
    res_rs1 = '0; res_rs2 = '0; res_pred_taken = 1'b0; pred_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("reset");
    chk_pred("reset.pred", 32'h100, 1'b0);
    rst_n = 1'b1;

    // first branch: beq taken, predicted not-taken
    req(32'h100, 3'b000, 32'd5, 32'd5, 1'b0, 1'b0);
    model(1'b1, 1'b1);
    chk_out("first", 1'b1, 1'b1, 1'b1, 1'b0);
    chk_cnt("first");
    chk_pred("first.pred", 32'h100, 1'b1);
    chk_pred("alias.pred", 32'h500, 1'b1);
    chk_pred("neighbor.pred", 32'h104, 1'b0);
    @(posedge clk); #1;
    chk("one_cycle.valid", {31'd0, out_valid}, 32'd0);

    // vector table; illegal entries use PC 0x604 whose counter must stay 01
    for (int i = 0; i < 12; i++) begin
      req(vt[i].e_ill ? 32'h604 : 32'h40, vt[i].f3, vt[i].a, vt[i].b, vt[i].pt, 1'b0);
      model(!vt[i].e_ill, vt[i].e_mis);
      chk_out($sformatf("vec%0d", i), 1'b1, vt[i].e_taken, vt[i].e_mis, vt[i].e_ill);
      chk_cnt($sformatf("vec%0d", i));
    end
    chk_pred("illegal.pred", 32'h604, 1'b0);

    // saturation at 0x200: 5 taken then 4 not-taken
    for (int i = 0; i < 5; i++) begin
      req(32'h200, 3'b000, 32'd0, 32'd0, 1'b1, 1'b0);
      model(1'b1, 1'b0);
      chk_pred($sformatf("sat_t%0d", i), 32'h200, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      req(32'h200, 3'b001, 32'd0, 32'd0, 1'b0, 1'b0);
      model(1'b1, 1'b0);
      chk_pred($sformatf("sat_n%0d", i), 32'h200, (i == 0));
    end
    // 00 reached: one taken only lifts to 01, still predicting not-taken
    req(32'h200, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    model(1'b1, 1'b1);
    chk_pred("sat_floor", 32'h200, 1'b0);
    chk_cnt("sat");

    // collision: prediction shows pre-update value
    pred_pc = 32'h300;
    res_valid = 1'b1; res_pc = 32'h300; res_funct3 = 3'b000;
    res_rs1 = 32'd7; res_rs2 = 32'd7; res_pred_taken = 1'b0; flush = 1'b0;
    #1;
    chk("collide.pre", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    model(1'b1, 1'b1);
    chk("collide.post", {31'd0, pred_taken}, 32'd1);
    chk_out("collide", 1'b1, 1'b1, 1'b1, 1'b0);

    // flush kills the result but not the BHT update or stats
    req(32'h308, 3'b000, 32'd1, 32'd1, 1'b0, 1'b1);
    model(1'b1, 1'b1);
    chk_out("flush", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_pred("flush.pred", 32'h308, 1'b1);
    chk_cnt("flush");

    // asynchronous reset between edges with a valid result showing
    req(32'h40, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("pre_rst.valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0; #1;
    bexp = 0; mexp = 0;
    chk_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("async_rst");
    chk_pred("async_rst.pred100", 32'h100, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 20 mispredicting branches saturate both counters at 15
    for (int i = 0; i < 20; i++) begin
      req(32'h40, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
      model(1'b1, 1'b1);
      chk_cnt($sformatf("stat%0d", i));
    end
    chk("stat.bmax", {28'd0, branch_count}, 32'd15);
    chk("stat.mmax", {28'd0, mispredict_count}, 32'd15);
    chk_pred("stat.pred", 32'h40, 1'b1);

    // reset held across an edge with a pending request: result discarded
    res_valid = 1'b1; res_pc = 32'h40; res_funct3 = 3'b000;
    res_rs1 = '0; res_rs2 = '0; res_pred_taken = 1'b0;
    rst_n = 1'b0; #1;
    chk_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    res_valid = 1'b0; rst_n = 1'b1;
    bexp = 0; mexp = 0;
    @(posedge clk); #1;
    chk_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("post_rst");
    chk_pred("post_rst.pred", 32'h40, 1'b0);
    req(32'h40, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
    model(1'b1, 1'b1);
    chk_out("cold", 1'b1, 1'b1, 1'b1, 1'b0);
    chk_cnt("cold");
    chk_pred("cold.pred", 32'h40, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
Parametrised branch resolution unit for the RV32I core, successor to the combinational take-branch decode. It compares full-width operands itself for all six B-type conditions, so it does not depend on ALU flag bits. It also holds a BHT of 2-bit saturating counters indexed by PC, which supplies a prediction at fetch. Resolution is registered one cycle after the execute-stage request, with mispredict detection and saturating statistics counters.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2
PC_LSB, 2, lowest PC bit used for the index (IDX_W = log2(BHT_ENTRIES))
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; kills the registered result of the current cycle
pred_pc  in  XLEN  fetch-stage PC to predict
pred_taken  out  1  combinational prediction, equal to counter[idx(pred_pc)][1]
res_valid  in  1  execute-stage branch resolution request
res_pc  in  XLEN  PC of the resolving branch
res_funct3  in  3  B-type funct3
res_rs1  in  XLEN  operand A
res_rs2  in  XLEN  operand B
res_pred_taken  in  1  prediction the branch carried down the pipe
out_valid  out  1  registered: a result is valid this cycle
out_taken  out  1  registered actual outcome
out_mispredict  out  1  registered: out_taken differs from the carried prediction
out_illegal  out  1  registered: funct3 was 010 or 011
branch_count  out  CNT_W  legal branches resolved, saturating
mispredict_count  out  CNT_W  mispredictions, saturating

Behaviour:
- Index: idx(pc) = pc[PC_LSB +: IDX_W].
- Conditions (full XLEN compare):
  - 000 beq: rs1==rs2
  - 001 bne: rs1!=rs2
  - 100 blt: signed rs1<rs2
  - 101 bge: signed rs1>=rs2
  - 110 bltu: unsigned rs1<rs2
  - 111 bgeu: unsigned rs1>=rs2
  - 010 and 011: illegal; taken=0.
- Latency: a request in cycle N drives out_* in cycle N+1. out_valid is high for exactly one cycle per request.
- out_valid(N+1) = res_valid(N) & ~flush(N). With flush high, out_valid=0 and out_taken, out_mispredict and out_illegal are all 0.
- out_mispredict = legal & (taken != res_pred_taken). It is always 0 for an illegal funct3.
- BHT update at the clock edge ending cycle N, when res_valid=1 and funct3 is legal. The update happens even when flush=1, because the branch did execute.
  - taken: counter = min(counter+1, 3)
  - not taken: counter = max(counter-1, 0)
  - illegal funct3: no update.
- Counter states: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Read/update collision, where idx(pred_pc)==idx(res_pc) in the same cycle: pred_taken reflects the pre-update value. There is no bypass.
- Statistics use the same qualification as the BHT update (res_valid, legal, flush ignored):
  - branch_count increments by 1 per qualifying request.
  - mispredict_count increments when that request mispredicts.
  - Both hold at 2^CNT_W-1 and do not wrap.
- Reset, asynchronous and taking effect immediately:
  - all BHT counters = 01
  - out_valid, out_taken, out_mispredict, out_illegal = 0
  - both statistics counters = 0
  - pred_taken consequently reads 0 for every PC.
- Reset asserted mid-operation discards any pending registered result. The first request after deassertion behaves as from cold state.
- Only PC bits in [PC_LSB, PC_LSB+IDX_W) influence prediction; PCs that alias share a counter.

Test Plan:
- Reset, then pred_pc=0x100 -> pred_taken=0. Request beq rs1=rs2=5, res_pred_taken=0 -> next cycle out_valid=1, out_taken=1, out_mispredict=1; counter[idx 0x40]=10; pred_taken for 0x100 is now 1; branch_count=1, mispredict_count=1.
- Signed/unsigned split with rs1=0xFFFFFFFF, rs2=0x00000001: blt -> taken=1; bltu -> 0; bge -> 0; bgeu -> 1.
- Saturation: five taken updates at PC 0x200 -> counter=11; one not-taken -> 10, so pred_taken stays 1; three further not-taken -> 00.
- Illegal funct3=010 with res_pred_taken=1 -> out_illegal=1, out_taken=0, out_mispredict=0; BHT and branch_count unchanged.
- Collision: pred_pc=res_pc=0x300 with counter=01 and a taken resolution in the same cycle -> pred_taken=0 that cycle and 1 the next. Flush with a request -> out_valid=0, but the counter still updates and branch_count increments.
- Counter saturation with CNT_W=4: 20 mispredicting branches -> both counters hold at 15. Assert rst_n low mid-stream -> all outputs 0 immediately and BHT back to 01.
